// File: rtl/ped_pkg.sv
// ped_pkg: shared definitions for the pedestrian request conditioner.
//   - ped_state_t : request FSM state encoding (IDLE=0, PENDING=1, SERVED=2, LOCKOUT=3)
//   - default timing constants for a 10 MHz system clock
package ped_pkg;

    localparam int unsigned PED_STATE_W = 2;

    typedef enum logic [PED_STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVED  = 2'd2,
        ST_LOCKOUT = 2'd3
    } ped_state_t;

    localparam int unsigned PED_SYNC_STAGES_DEF     = 2;
    localparam int unsigned PED_DEBOUNCE_CYCLES_DEF = 200000;   // 20 ms @ 10 MHz
    localparam int unsigned PED_LOCKOUT_CYCLES_DEF  = 10000000; // 1 s @ 10 MHz

endpackage : ped_pkg

// File: rtl/btn_debounce.sv
// btn_debounce: synchroniser, debouncer and press detector for an active-low
// asynchronous pushbutton.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous reset, active-high
//   btn_n  in  raw pushbutton, active-low, asynchronous, bouncy
//   press  out one-cycle pulse per debounced press (released -> pressed)
// Parameters:
//   SYNC_STAGES      synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing cycles needed before the debounced level flips
module btn_debounce
    import ped_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = PED_SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = PED_DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_debounce: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic                   btn_db;
    logic [CNT_W-1:0]       cnt;

    // Synchroniser resets to all-ones: the button reads as released.
    assign btn_s = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            cnt    <= '0;
            btn_db <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
            press  <= 1'b0;
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_db <= btn_s;
                cnt    <= '0;
                // Registered rising edge of btn_db, raised together with the flip
                // instead of one cycle later from a btn_db delay flop.
                press  <= btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : btn_debounce

// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner: conditions the pedestrian pushbutton into a latched,
// active-low request for the crosswalk controller. The request is held until the
// controller leaves vehicle-green (falling edge of veh_green).
// Ports:
//   clk          in  system clock (10 MHz)
//   rst          in  asynchronous reset, active-high
//   btn_n        in  raw pushbutton, active-low, asynchronous
//   en           in  run enable; 0 flushes the FSM to IDLE (debouncer keeps running)
//   veh_green    in  controller vehicle-green lamp, used as acknowledge
//   req_n        out request to controller, active-low level
//   req_pending  out request-latched indicator, active-high
//   press_pulse  out one-cycle pulse per press accepted into PENDING
// Configuration:
//   PED_LOCKOUT_EN defined   : SERVED -> LOCKOUT (LOCKOUT_CYCLES) -> IDLE, presses dropped
//   PED_LOCKOUT_EN undefined : SERVED -> IDLE, LOCKOUT_CYCLES unused
module ped_request_conditioner
    import ped_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = PED_SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = PED_DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LOCKOUT_CYCLES  = PED_LOCKOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    input  logic en,
    input  logic veh_green,
    output logic req_n,
    output logic req_pending,
    output logic press_pulse
);

    if (LOCKOUT_CYCLES < 1) begin : g_bad_lock
        $error("ped_request_conditioner: LOCKOUT_CYCLES must be at least 1");
    end

    ped_state_t state;
    logic       press;
    logic       veh_green_q;
    logic       ack;

`ifdef PED_LOCKOUT_EN
    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
    logic [LOCK_W-1:0] lock_cnt;
`endif

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn_n(btn_n),
        .press(press)
    );

    // Controller leaving vehicle-green acknowledges the request.
    assign ack = veh_green_q & ~veh_green;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_n       <= 1'b1;
            req_pending <= 1'b0;
            press_pulse <= 1'b0;
            veh_green_q <= 1'b0;
`ifdef PED_LOCKOUT_EN
            lock_cnt    <= '0;
`endif
        end else begin
            veh_green_q <= veh_green;
            press_pulse <= 1'b0;
            if (!en) begin
                state       <= ST_IDLE;
                req_n       <= 1'b1;
                req_pending <= 1'b0;
`ifdef PED_LOCKOUT_EN
                lock_cnt    <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press) begin
                            state       <= ST_PENDING;
                            req_n       <= 1'b0;
                            req_pending <= 1'b1;
                            press_pulse <= 1'b1;
                        end
                    end
                    ST_PENDING: begin
                        // Further presses are ignored here: no queuing.
                        if (ack) begin
                            state       <= ST_SERVED;
                            req_n       <= 1'b1;
                            req_pending <= 1'b0;
                        end
                    end
                    ST_SERVED: begin
`ifdef PED_LOCKOUT_EN
                        state    <= ST_LOCKOUT;
                        lock_cnt <= '0;
`else
                        state    <= ST_IDLE;
`endif
                    end
`ifdef PED_LOCKOUT_EN
                    ST_LOCKOUT: begin
                        if (lock_cnt == LOCK_LAST) begin
                            state    <= ST_IDLE;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state       <= ST_IDLE;
                        req_n       <= 1'b1;
                        req_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : ped_request_conditioner

// File: tb/tb_ped_request_conditioner.sv
module tb_ped_request_conditioner;

    localparam int S = 2;
    localparam int D = 8;
    localparam int L = 16;
`ifdef PED_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_n = 1'b1;
    logic en = 1'b0;
    logic veh_green = 1'b0;
    logic req_n, req_pending, press_pulse;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    bit cmp_en = 1'b1;

    ped_request_conditioner #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .en         (en),
        .veh_green  (veh_green),
        .req_n      (req_n),
        .req_pending(req_pending),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[0] is the newest sampled btn_n; btn_s seen at an edge is ~hist[S].
    bit hist [S+D];
    bit m_db, m_press, m_pending, m_served, m_pulse, m_vg_q;
    int m_lock;

    task automatic model_reset();
        for (int i = 0; i < S + D; i++) hist[i] = 1'b1;
        m_db = 0; m_press = 0; m_pending = 0; m_served = 0;
        m_pulse = 0; m_vg_q = 0; m_lock = 0;
    endtask

    task automatic model_step();
        bit ack;
        bit all_diff;
        ack = m_vg_q & ~veh_green;
        m_pulse = 0;
        if (!en) begin
            m_pending = 0; m_served = 0; m_lock = 0;
        end else if (m_pending) begin
            if (ack) begin m_pending = 0; m_served = 1; end
        end else if (m_served) begin
            m_served = 0;
            m_lock = LOCK_EN ? L : 0;
        end else if (m_lock > 0) begin
            m_lock--;
        end else if (m_press) begin
            m_pending = 1; m_pulse = 1;
        end
        m_vg_q = veh_green;
        // Debounced level flips once the last D synchronised samples all disagree with it.
        for (int i = S + D - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = btn_n;
        all_diff = 1;
        for (int i = 0; i < D; i++) if ((!hist[S+i]) == m_db) all_diff = 0;
        m_press = 0;
        if (all_diff) begin
            m_db = !m_db;
            m_press = m_db;
        end
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            if (rst) begin
                check("rst_req_n", req_n, 1);
                check("rst_req_pending", req_pending, 0);
                check("rst_press_pulse", press_pulse, 0);
            end else begin
                check("model_req_n", req_n, !m_pending);
                check("model_req_pending", req_pending, m_pending);
                check("model_press_pulse", press_pulse, m_pulse);
            end
            if (press_pulse === 1'b1) pulse_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clean_press(input int len);
        btn_n = 1'b0;
        tick(len);
        btn_n = 1'b1;
        tick(D + S + 4);
    endtask

    int lat;
    int btn_timer;
    int en_off;

    initial begin
        model_reset();
        tick(3);
        rst = 1'b0;
        en = 1'b1;
        tick(2);
        check("reset_req_n", req_n, 1);
        check("reset_req_pending", req_pending, 0);
        check("reset_press_pulse", press_pulse, 0);

        // Clean press while green: one pulse after sync+debounce latency, request held.
        veh_green = 1'b1;
        tick(2);
        pulse_cnt = 0;
        lat = -1;
        btn_n = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (press_pulse === 1'b1 && lat < 0) lat = i;
        end
        btn_n = 1'b1;
        check("press_latency_window", (lat >= S + D - 1 && lat <= S + D + 1), 1);
        check("held_press_one_pulse", pulse_cnt, 1);
        check("pending_req_n", req_n, 0);
        check("pending_led", req_pending, 1);
        tick(20);

        // Second press while pending is not queued.
        pulse_cnt = 0;
        clean_press(15);
        check("pending_no_second_pulse", pulse_cnt, 0);
        check("pending_still_req_n", req_n, 0);

        // Acknowledge: green -> not-green releases the request one cycle later.
        veh_green = 1'b0;
        tick(1);
        check("ack_req_n", req_n, 1);
        check("ack_req_pending", req_pending, 0);

        // Press right after service: dropped under lockout, accepted otherwise.
        pulse_cnt = 0;
        clean_press(15);
`ifdef PED_LOCKOUT_EN
        check("lockout_press_dropped", pulse_cnt, 0);
        check("lockout_req_n", req_n, 1);
        tick(L);
        pulse_cnt = 0;
        clean_press(15);
        check("post_lockout_press", pulse_cnt, 1);
`else
        check("post_service_press", pulse_cnt, 1);
`endif
        // Pressed while not green: rising green is not an ack, falling green is.
        check("red_press_held", req_n, 0);
        veh_green = 1'b1;
        tick(5);
        check("green_rise_no_ack", req_n, 0);
        veh_green = 1'b0;
        tick(1);
        check("green_fall_ack", req_n, 1);
        tick(L + 4);

        // Bounce: short low glitches never produce a press.
        pulse_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            btn_n = 1'b0; tick(3);
            btn_n = 1'b1; tick(3);
        end
        tick(20);
        check("bounce_no_pulse", pulse_cnt, 0);
        check("bounce_req_n", req_n, 1);

        // en=0 flushes a pending request; a new press after re-enable is accepted.
        veh_green = 1'b1;
        tick(2);
        clean_press(15);
        check("en_pre_req_n", req_n, 0);
        en = 1'b0;
        tick(1);
        check("en_flush_req_n", req_n, 1);
        check("en_flush_led", req_pending, 0);
        en = 1'b1;
        tick(2);
        pulse_cnt = 0;
        clean_press(15);
        check("en_repress_pulse", pulse_cnt, 1);
        check("en_repress_req_n", req_n, 0);

        // Asynchronous reset mid-PENDING drops the request without a clock edge.
        rst = 1'b1;
        #1;
        check("async_rst_req_n", req_n, 1);
        check("async_rst_led", req_pending, 0);
        check("async_rst_pulse", press_pulse, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Randomised run against the model.
        btn_timer = 0;
        en_off = 0;
        for (int c = 0; c < 4000; c++) begin
            if (btn_timer == 0) begin
                btn_n = ~btn_n;
                btn_timer = (btn_n == 1'b0) ? $urandom_range(1, 25) : $urandom_range(1, 30);
            end else begin
                btn_timer--;
            end
            if ($urandom_range(0, 29) == 0) veh_green = ~veh_green;
            if (en_off > 0) begin
                en_off--;
                if (en_off == 0) en = 1'b1;
            end else if ($urandom_range(0, 249) == 0) begin
                en = 1'b0;
                en_off = $urandom_range(1, 4);
            end
            tick(1);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ped_request_conditioner
